demux4w_dispatcher: RTL

Controller sequencing the 4-way demultiplexer.
- Accepts a valid/ready word stream on one input and dispatches each word to exactly one of four output channels.
- Channel choice is round-robin, optionally skipping channels not ready at load time.
- Drives the 2-bit select of a 1-to-4 demux datapath.
- Holds each word in a one-entry buffer until the chosen channel accepts it.

---
 rtl/demux4w_pkg.sv | 10 +
 rtl/demux4w_dispatcher_rr_pick4.sv | 33 +++
 rtl/demux4w_dispatcher.sv | 106 ++++++++++
 3 files changed

// File: rtl/demux4w_pkg.sv
// Shared types and constants for the 4-way demux dispatcher.
package demux4w_pkg;

   localparam int unsigned NUM_CH = 4;

   typedef logic [1:0] sel_t;

   typedef enum logic {IDLE, HOLD} state_t;

endpackage

// File: rtl/demux4w_dispatcher_rr_pick4.sv
// Round-robin channel picker. With skip set, it returns the first requesting
// channel at or after ptr (mod 4). If skip is clear or nothing requests, it
// returns ptr.
module rr_pick4
   import demux4w_pkg::*;
(
   input  sel_t       ptr,
   input  logic [3:0] req,
   input  logic       skip,
   output sel_t       pick
);

   logic [7:0] req_dbl;
   logic [3:0] req_rot;
   sel_t       offset;

   // Rotate req so that bit 0 is the channel ptr points at.
   assign req_dbl = {req, req};
   assign req_rot = req_dbl[ptr +: 4];

   // Priority search over the rotated request vector.
   always_comb begin
      offset = 2'd0;
      if (skip) begin
         if (req_rot[0])      offset = 2'd0;
         else if (req_rot[1]) offset = 2'd1;
         else if (req_rot[2]) offset = 2'd2;
         else if (req_rot[3]) offset = 2'd3;
      end
      pick = ptr + offset;
   end

endmodule

// File: rtl/demux4w_dispatcher.sv
// Valid/ready dispatcher that drives a 1-to-4 demux. It holds one word and
// sends it to a channel picked by round-robin.
// Optional macro DEMUX4W_DISPATCH_CNT_EN adds per-channel handshake counters
// on the cnt port.
module demux4w_dispatcher
   import demux4w_pkg::*;
#(
   parameter int unsigned WIDTH     = 1,
   parameter bit          SKIP_BUSY = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   output logic [1:0]           sel,
   output logic [3:0]           out_valid,
   input  logic [3:0]           out_ready,
   output logic [4*WIDTH-1:0]   out_data,
   output logic                 busy
`ifdef DEMUX4W_DISPATCH_CNT_EN
   ,
   output logic [31:0]          cnt
`endif
);

   state_t           state_q, state_d;
   sel_t             ptr_q, ptr_d, ptr_eff;
   sel_t             sel_q, sel_d, pick;
   logic [WIDTH-1:0] data_q, data_d;
   logic             hold, accept, load;

   assign hold    = (state_q == HOLD);
   assign accept  = hold & out_ready[sel_q];
   // The pointer advance from this cycle's handshake feeds a same-cycle reload.
   assign ptr_eff = accept ? sel_q + 2'd1 : ptr_q;
   assign load    = in_valid & in_ready;

   rr_pick4 u_pick (
      .ptr  (ptr_eff),
      .req  (out_ready),
      .skip (SKIP_BUSY),
      .pick (pick)
   );

   // Outputs: the held word goes on the selected lane. All other lanes read zero.
   always_comb begin
      in_ready  = rst_n & (hold ? out_ready[sel_q] : 1'b1);
      out_valid = '0;
      out_data  = '0;
      if (hold) begin
         out_valid[sel_q]                 = 1'b1;
         out_data[sel_q*WIDTH +: WIDTH]   = data_q;
      end
   end

   assign sel  = sel_q;
   assign busy = hold;

   // Next state: a load has priority over going idle after a handshake.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      data_d  = data_q;
      ptr_d   = ptr_eff;
      if (load) begin
         state_d = HOLD;
         sel_d   = pick;
         data_d  = in_data;
      end else if (accept) begin
         state_d = IDLE;
         data_d  = '0;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
      end
   end

`ifdef DEMUX4W_DISPATCH_CNT_EN
   logic [3:0][7:0] cnt_q;

   // Per-channel count of completed output handshakes. Each lane wraps at 256.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q[sel_q] <= cnt_q[sel_q] + 8'd1;
      end
   end

   assign cnt = cnt_q;
`endif

endmodule
